// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state encoding and error results for the ALU sequencer
package alu_pkg;

    localparam int OP_W     = 3;
    localparam int STROBE_W = 5;

    localparam logic [OP_W-1:0] OP_CMP = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_WAIT_B = 3'd2;
    localparam logic [2:0] ST_LOAD_B = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_A = ST_LOAD_A,
        WAIT_B = ST_WAIT_B,
        LOAD_B = ST_LOAD_B,
        EXEC   = ST_EXEC,
        DONE   = ST_DONE
    } seqState_t;

    localparam logic [7:0] RES_ILLEGAL = 8'hFF;
    localparam logic [7:0] RES_DIV0    = 8'h00;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - opcode to one-hot strobe decode with illegal/divide-by-zero detection
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]     opCode,
    input  logic [3:0]          bNib,
    output logic [STROBE_W-1:0] strobe,
    output logic                illegal,
    output logic                div0
);

    // Strobe bit index equals the opcode; error cases raise no strobe at all
    always_comb begin
        illegal = (opCode > OP_MUL);
        div0    = (opCode == OP_DIV) && (bNib == 4'd0);
        strobe  = '0;
        if (!illegal && !div0) begin
            strobe = STROBE_W'(1) << opCode;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - nibble stream to ALU datapath load/strobe sequencer with result handshake
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int RESULT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    input  logic [2:0]  in_op,
    output logic [3:0]  Datain,
    output logic        ldA,
    output logic        ldB,
    output logic        aCmp,
    output logic        aAdd,
    output logic        aSub,
    output logic        aDiv,
    output logic        aMul,
    input  logic [7:0]  Y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_err
);

    seqState_t             state;
    seqState_t             nextState;
    logic [OP_W-1:0]       opReg;
    logic [3:0]            bNib;
    logic [3:0]            latCnt;
    logic [STROBE_W-1:0]   strobeReg;
    logic [STROBE_W-1:0]   decStrobe;
    logic                  decIllegal;
    logic                  decDiv0;
    logic                  acceptA;
    logic                  acceptB;

    // Decode works on the latched opcode/B so LOAD_B sees stable inputs
    alu_op_decode uDecode (
        .opCode  (opReg),
        .bNib    (bNib),
        .strobe  (decStrobe),
        .illegal (decIllegal),
        .div0    (decDiv0)
    );

    assign acceptA = (state == IDLE)   && in_valid;
    assign acceptB = (state == WAIT_B) && in_valid;

    // Every output is a flop or a decode of the state flop only
    assign in_ready  = (state == IDLE) || (state == WAIT_B);
    assign ldA       = (state == LOAD_A);
    assign ldB       = (state == LOAD_B);
    assign res_valid = (state == DONE);
    assign {aMul, aDiv, aSub, aAdd, aCmp} = strobeReg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: error operations skip EXEC and report straight away
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (in_valid) nextState = LOAD_A;
            LOAD_A:  nextState = WAIT_B;
            WAIT_B:  if (in_valid) nextState = LOAD_B;
            LOAD_B:  nextState = (decIllegal || decDiv0) ? DONE : EXEC;
            EXEC:    if (latCnt == 4'd0) nextState = DONE;
            DONE:    if (res_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand, latency counter, strobe and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Datain    <= '0;
            opReg     <= '0;
            bNib      <= '0;
            latCnt    <= '0;
            strobeReg <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            if (acceptA) begin
                Datain <= in_data;
            end
            if (acceptB) begin
                Datain <= in_data;
                opReg  <= in_op;
                bNib   <= in_data;
            end
            case (state)
                LOAD_B: begin
                    if (decIllegal) begin
                        res_data <= RES_ILLEGAL;
                        res_err  <= 1'b1;
                    end else if (decDiv0) begin
                        res_data <= RES_DIV0;
                        res_err  <= 1'b1;
                    end else begin
                        strobeReg <= decStrobe;
                        latCnt    <= 4'(RESULT_LAT - 1);
                    end
                end
                EXEC: begin
                    if (latCnt == 4'd0) begin
                        strobeReg <= '0;
                        res_data  <= Y;
                        res_err   <= 1'b0;
                    end else begin
                        latCnt <= latCnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural datapath
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic [2:0] in_op = '0;
    logic [3:0] Datain;
    logic       ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul;
    logic [7:0] Y = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;

    int vectors = 0;
    int miscompares = 0;
    bit lastAccept = 1'b0;

    logic [3:0] dpA;
    logic [3:0] dpB = '0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        int         hold;
        logic [7:0] expData;
        logic       expErr;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    alu_sequencer #(.RESULT_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .Datain    (Datain),
        .ldA       (ldA),
        .ldB       (ldB),
        .aCmp      (aCmp),
        .aAdd      (aAdd),
        .aSub      (aSub),
        .aDiv      (aDiv),
        .aMul      (aMul),
        .Y         (Y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    // Clocked datapath: operand registers are never reset, result follows the active strobe
    always @(posedge clk) begin
        if (ldA) dpA <= Datain;
        if (ldB) dpB <= Datain;
        if (aCmp)      Y <= {6'd0, dpA > dpB, dpA == dpB};
        else if (aAdd) Y <= {4'd0, dpA} + {4'd0, dpB};
        else if (aSub) Y <= {4'd0, dpA} - {4'd0, dpB};
        else if (aDiv) Y <= {4'd0, dpA / dpB};
        else if (aMul) Y <= {4'd0, dpA} * {4'd0, dpB};
    end

    function automatic logic [8:0] refModel(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ai = int'(a);
        int bi = int'(b);
        case (op)
            3'd0:    return {1'b0, 8'((ai > bi) ? 2 : ((ai == bi) ? 1 : 0))};
            3'd1:    return {1'b0, 8'(ai + bi)};
            3'd2:    return {1'b0, 8'(ai - bi)};
            3'd3:    return (bi == 0) ? 9'h100 : {1'b0, 8'(ai / bi)};
            3'd4:    return {1'b0, 8'(ai * bi)};
            default: return 9'h1FF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        lastAccept = in_valid && in_ready;
        @(posedge clk);
        #1;
        check("onehot", 32'($countones({ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul}) <= 1), 32'd1);
        check("stall", 32'(in_ready && (ldA || ldB || aCmp || aAdd || aSub || aDiv || aMul || res_valid)), 32'd0);
    endtask

    task automatic sendA(input logic [3:0] a);
        int n = 0;
        in_valid = 1'b1;
        in_data  = a;
        in_op    = 3'($urandom);
        do begin
            step();
            n++;
        end while (!lastAccept && n < 30);
        check("a_accept", 32'(lastAccept), 32'd1);
        in_valid = 1'b0;
        check("ldA_pulse", 32'(ldA), 32'd1);
        check("Datain_A", 32'(Datain), 32'(a));
    endtask

    task automatic sendB(input logic [3:0] b, input logic [2:0] op, input int gap);
        int n = 0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        in_op    = op;
        do begin
            step();
            n++;
        end while (!lastAccept && n < 30);
        check("b_accept", 32'(lastAccept), 32'd1);
        in_valid = 1'b0;
        check("ldB_pulse", 32'(ldB), 32'd1);
        check("Datain_B", 32'(Datain), 32'(b));
    endtask

    task automatic finishTxn(input logic [7:0] expData, input logic expErr, input int hold, input logic [2:0] op);
        int k = 1;
        int strobeCyc = 0;
        int badStrobe = 0;
        logic [4:0] stb;
        logic [4:0] want;
        want = expErr ? 5'd0 : (5'd1 << op);
        res_ready = (hold == 0);
        while (!res_valid && k < 40) begin
            step();
            k++;
            stb = {aMul, aDiv, aSub, aAdd, aCmp};
            if (!res_valid) begin
                if (want != 5'd0 && stb == want) strobeCyc++;
                else if (stb != 5'd0) badStrobe++;
            end
        end
        check("res_latency", 32'(k), 32'(expErr ? 2 : 2 + LAT));
        check("strobe_cycles", 32'(strobeCyc), 32'(expErr ? 0 : LAT));
        check("wrong_strobe", 32'(badStrobe), 32'd0);
        check("strobe_off_done", 32'({aMul, aDiv, aSub, aAdd, aCmp}), 32'd0);
        check("res_data", 32'(res_data), 32'(expData));
        check("res_err", 32'(res_err), 32'(expErr));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'(expData));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        step();
        check("release_valid", 32'(res_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [8:0] r;
        int n;

        tbl[0] = '{4'd3,  4'd5,  OP_ADD, 0,  8'h08, 1'b0};
        tbl[1] = '{4'd4,  4'd2,  3'd6,   0,  8'hFF, 1'b1};
        tbl[2] = '{4'd9,  4'd0,  OP_DIV, 1,  8'h00, 1'b1};
        tbl[3] = '{4'd15, 4'd15, OP_MUL, 10, 8'hE1, 1'b0};
        tbl[4] = '{4'd7,  4'd2,  OP_SUB, 0,  8'h05, 1'b0};
        tbl[5] = '{4'd6,  4'd6,  OP_CMP, 2,  8'h01, 1'b0};
        tbl[6] = '{4'd9,  4'd2,  OP_CMP, 0,  8'h02, 1'b0};
        tbl[7] = '{4'd13, 4'd4,  OP_DIV, 0,  8'h03, 1'b0};
        tbl[8] = '{4'd1,  4'd1,  3'd5,   3,  8'hFF, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_Datain", 32'(Datain), 32'd0);
        check("rst_strobes", 32'({ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul}), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            sendA(tbl[i].a);
            sendB(tbl[i].b, tbl[i].op, i % 3);
            finishTxn(tbl[i].expData, tbl[i].expErr, tbl[i].hold, tbl[i].op);
        end

        sendA(4'd8);
        sendB(4'd3, OP_SUB, 0);
        n = 0;
        while (!aSub && n < 10) begin
            step();
            n++;
        end
        check("sub_strobe_seen", 32'(aSub), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_strobes", 32'({ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul}), 32'd0);
        check("async_rst_Datain", 32'(Datain), 32'd0);
        check("async_rst_res", 32'({res_valid, res_err, res_data}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        sendA(4'd2);
        sendB(4'd11, OP_CMP, 1);
        finishTxn(8'h00, 1'b0, 0, OP_CMP);

        for (int i = 0; i < 40; i++) begin
            a  = 4'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            op = 3'($urandom_range(0, 7));
            r  = refModel(a, b, op);
            repeat ($urandom_range(0, 2)) step();
            sendA(a);
            sendB(b, op, int'($urandom_range(0, 2)));
            finishTxn(r[7:0], r[8], int'($urandom_range(0, 3)), op);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
